// File: rtl/oflow_dispatch_pkg.sv
// Shared types and default widths for the oflow bbox dispatch front end.
package oflow_dispatch_pkg;

    // Bbox vector width consumed by the PE feature-extraction input.
    localparam int unsigned PE_BBOX_W    = 64;

    localparam int unsigned NUM_PE_DEF   = 8;
    localparam int unsigned BBOX_W_DEF   = PE_BBOX_W;
    localparam int unsigned MAX_BBOX_DEF = 63;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } disp_state_t;

endpackage

// File: rtl/oflow_done_collector.sv
// Sticky record of which launched PEs have reported done_fe for the current batch.
module oflow_done_collector
    import oflow_dispatch_pkg::*;
#(
    parameter int unsigned NUM_PE = NUM_PE_DEF
) (
    input  logic              clk,
    input  logic              reset_N,
    input  logic              i_capture,
    input  logic              i_clear,
    input  logic [NUM_PE-1:0] i_loaded_mask,
    input  logic [NUM_PE-1:0] i_done_fe,
    output logic              o_all_done_c
);

    logic [NUM_PE-1:0] r_done_mask;
    logic [NUM_PE-1:0] w_hits;
    logic [NUM_PE-1:0] w_merged;

    // Completions from PEs that were not launched are dropped here.
    assign w_hits       = i_capture ? (i_done_fe & i_loaded_mask) : '0;
    assign w_merged     = r_done_mask | w_hits;
    // Includes this cycle's arrivals so the batch can close on the following edge.
    assign o_all_done_c = i_capture && (w_merged == i_loaded_mask);

    // Accumulate done bits; a clear wins over a same-cycle capture.
    always_ff @(posedge clk) begin
        if (reset_N) begin
            r_done_mask <= '0;
        end else if (i_clear) begin
            r_done_mask <= '0;
        end else begin
            r_done_mask <= w_merged;
        end
    end

endmodule

// File: rtl/oflow_bbox_dispatcher.sv
// Packs a frame's DMA bbox stream into PE-sized batches and launches/awaits each batch.
module oflow_bbox_dispatcher
    import oflow_dispatch_pkg::*;
#(
    parameter  int unsigned NUM_PE   = NUM_PE_DEF,
    parameter  int unsigned BBOX_W   = BBOX_W_DEF,
    parameter  int unsigned MAX_BBOX = MAX_BBOX_DEF,
    localparam int unsigned CNT_W    = $clog2(MAX_BBOX + 1)
) (
    input  logic                           clk,
    input  logic                           reset_N,
    input  logic                           start_frame,
    input  logic [CNT_W-1:0]               num_of_bbox,
    input  logic                           dma_valid,
    input  logic [BBOX_W-1:0]              dma_bbox,
    output logic                           dma_ready,
    output logic [NUM_PE-1:0][BBOX_W-1:0]  bbox_to_pe,
    output logic [NUM_PE-1:0]              start_fe,
    input  logic [NUM_PE-1:0]              done_fe,
    output logic [CNT_W-1:0]               batch_idx,
    output logic                           busy,
    output logic                           done_dispatch
);

    localparam int unsigned SLOT_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    disp_state_t                  r_state;
    disp_state_t                  w_state_nxt;

    logic [CNT_W-1:0]             r_remaining;
    logic [CNT_W-1:0]             w_remaining_nxt;
    logic [SLOT_W-1:0]            r_slot;
    logic [SLOT_W-1:0]            w_slot_nxt;
    logic [NUM_PE-1:0]            r_loaded_mask;
    logic [NUM_PE-1:0]            w_loaded_nxt;
    logic [CNT_W-1:0]             r_batch_idx;
    logic [CNT_W-1:0]             w_batch_nxt;
    logic [NUM_PE-1:0][BBOX_W-1:0] r_bbox;
    logic [NUM_PE-1:0]            r_start_fe;
    logic [NUM_PE-1:0]            w_start_fe_nxt;
    logic                         r_busy;
    logic                         r_done_dispatch;

    logic                         w_accept;
    logic                         w_capture;
    logic                         w_clear;
    logic                         w_all_done;
    logic [CNT_W:0]               w_num_ext;
    logic [CNT_W-1:0]             w_num_sat;

    // Requested count clamped to the frame maximum.
    assign w_num_ext = {1'b0, num_of_bbox};
    assign w_num_sat = (w_num_ext > (CNT_W+1)'(MAX_BBOX)) ? CNT_W'(MAX_BBOX) : num_of_bbox;

    // Ready is decoded from state so a bbox can be taken every LOAD cycle.
    assign dma_ready = (r_state == S_LOAD);
    assign w_accept  = dma_ready && dma_valid;

    oflow_done_collector #(
        .NUM_PE (NUM_PE)
    ) u_done_collector (
        .clk           (clk),
        .reset_N       (reset_N),
        .i_capture     (w_capture),
        .i_clear       (w_clear),
        .i_loaded_mask (r_loaded_mask),
        .i_done_fe     (done_fe),
        .o_all_done_c  (w_all_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and mask updates, plus next values of registered outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_slot_nxt      = r_slot;
        w_loaded_nxt    = r_loaded_mask;
        w_batch_nxt     = r_batch_idx;
        w_capture       = 1'b0;
        w_clear         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_frame) begin
                    w_remaining_nxt = w_num_sat;
                    w_slot_nxt      = '0;
                    w_batch_nxt     = '0;
                    w_loaded_nxt    = '0;
                    w_clear         = 1'b1;
                    w_state_nxt     = (w_num_sat == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (dma_valid) begin
                    w_loaded_nxt[r_slot] = 1'b1;
                    w_slot_nxt           = r_slot + SLOT_W'(1);
                    if (r_remaining != '0) begin
                        w_remaining_nxt = r_remaining - CNT_W'(1);
                    end
                    if ((r_slot == SLOT_W'(NUM_PE - 1)) || (r_remaining <= CNT_W'(1))) begin
                        w_state_nxt = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_capture = 1'b1;
                if (w_all_done) begin
                    w_clear      = 1'b1;
                    w_loaded_nxt = '0;
                    w_slot_nxt   = '0;
                    if (r_remaining != '0) begin
                        w_batch_nxt = r_batch_idx + CNT_W'(1);
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_start_fe_nxt = (w_state_nxt == S_LAUNCH) ? w_loaded_nxt : '0;
    end

    // Datapath registers; bbox slots only change when a bbox is accepted into them.
    always_ff @(posedge clk) begin
        if (reset_N) begin
            r_remaining     <= '0;
            r_slot          <= '0;
            r_loaded_mask   <= '0;
            r_batch_idx     <= '0;
            r_bbox          <= '0;
            r_start_fe      <= '0;
            r_busy          <= 1'b0;
            r_done_dispatch <= 1'b0;
        end else begin
            r_remaining     <= w_remaining_nxt;
            r_slot          <= w_slot_nxt;
            r_loaded_mask   <= w_loaded_nxt;
            r_batch_idx     <= w_batch_nxt;
            r_start_fe      <= w_start_fe_nxt;
            r_busy          <= (w_state_nxt != S_IDLE);
            r_done_dispatch <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_bbox[r_slot] <= dma_bbox;
            end
        end
    end

    assign bbox_to_pe    = r_bbox;
    assign start_fe      = r_start_fe;
    assign batch_idx     = r_batch_idx;
    assign busy          = r_busy;
    assign done_dispatch = r_done_dispatch;

endmodule

// File: tb/tb_oflow_bbox_dispatcher.sv
// Scoreboard bench for oflow_bbox_dispatcher: batch model feeds queues, a monitor checks launches/done.
module tb_oflow_bbox_dispatcher;

    localparam int unsigned NPE   = 8;
    localparam int unsigned BW    = 64;
    localparam int unsigned MAXB  = 63;
    localparam int unsigned CW    = 6;

    typedef struct {
        logic [NPE-1:0]          mask;
        logic [CW-1:0]           bidx;
        logic [NPE-1:0][BW-1:0]  data;
    } launch_t;

    typedef struct {
        int nbatch;
        int start_cyc;
        bit empty;
    } frame_t;

    logic                    clk = 1'b0;
    logic                    reset_N;
    logic                    start_frame;
    logic [CW-1:0]           num_of_bbox;
    logic                    dma_valid;
    logic [BW-1:0]           dma_bbox;
    logic                    dma_ready;
    logic [NPE-1:0][BW-1:0]  bbox_to_pe;
    logic [NPE-1:0]          start_fe;
    logic [NPE-1:0]          done_fe;
    logic [CW-1:0]           batch_idx;
    logic                    busy;
    logic                    done_dispatch;

    int      cyc = 0;
    int      total = 0;
    int      bad = 0;
    int      last_final_cyc = -100;
    bit      pe_auto = 1'b0;
    bit      dma_abort = 1'b0;

    launch_t      exp_launch_q[$];
    frame_t       exp_done_q[$];
    logic [BW-1:0] frame_bb[$];
    logic [BW-1:0] model_slots[NPE];

    oflow_bbox_dispatcher #(
        .NUM_PE   (NPE),
        .BBOX_W   (BW),
        .MAX_BBOX (MAXB)
    ) dut (
        .clk           (clk),
        .reset_N       (reset_N),
        .start_frame   (start_frame),
        .num_of_bbox   (num_of_bbox),
        .dma_valid     (dma_valid),
        .dma_bbox      (dma_bbox),
        .dma_ready     (dma_ready),
        .bbox_to_pe    (bbox_to_pe),
        .start_fe      (start_fe),
        .done_fe       (done_fe),
        .batch_idx     (batch_idx),
        .busy          (busy),
        .done_dispatch (done_dispatch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame of n bboxes becomes ceil(n/NPE) batches filled in slot order.
    task automatic model_frame(input int n, input int start_cyc);
        frame_t f;
        int nb;
        nb = (n + NPE - 1) / NPE;
        for (int b = 0; b < nb; b++) begin
            launch_t e;
            int k;
            k = ((n - b * NPE) > NPE) ? NPE : (n - b * NPE);
            e.mask = NPE'((1 << k) - 1);
            e.bidx = CW'(b);
            for (int s = 0; s < k; s++) model_slots[s] = frame_bb[b * NPE + s];
            for (int s = 0; s < NPE; s++) e.data[s] = model_slots[s];
            exp_launch_q.push_back(e);
        end
        f.nbatch    = nb;
        f.start_cyc = start_cyc;
        f.empty     = (n == 0);
        exp_done_q.push_back(f);
    endtask

    // Generates bbox data, queues the expectation, and pulses start_frame; returns in the cycle after.
    task automatic start_new_frame(input int n);
        frame_bb.delete();
        for (int i = 0; i < n; i++) frame_bb.push_back({$urandom(), $urandom()});
        @(posedge clk); #1;
        start_frame = 1'b1;
        num_of_bbox = CW'(n);
        model_frame(n, cyc);
        @(posedge clk); #1;
        start_frame = 1'b0;
    endtask

    // Offers bboxes with random or patterned valid gaps, holding each until accepted.
    task automatic dma_feed(input int n, input int gap_pct, input bit use_pat, input logic [15:0] pat);
        int  idx;
        int  t;
        int  guard;
        bit  acc;
        idx = 0; t = 0; guard = 0;
        while (idx < n && !dma_abort) begin
            if (!dma_valid) begin
                if (use_pat) dma_valid = (t < 16) ? pat[t] : 1'b1;
                else         dma_valid = ($urandom_range(99) >= gap_pct);
                dma_bbox = frame_bb[idx];
            end
            t++;
            @(negedge clk);
            acc = dma_valid && dma_ready;
            if (acc) idx++;
            @(posedge clk); #1;
            if (acc) dma_valid = 1'b0;
            guard++;
            if (guard > 3000) begin
                chk("dma_feed_timeout", 64'(idx), 64'(n));
                break;
            end
        end
        dma_valid = 1'b0;
    endtask

    // Automatic PE model: every launched PE answers 1..5 cycles later, with stray bits on idle PEs.
    task automatic pe_responder();
        logic [NPE-1:0] launched;
        logic [NPE-1:0] pending;
        logic [NPE-1:0] d;
        int             due[NPE];
        forever begin
            @(negedge clk);
            if (pe_auto && !reset_N && start_fe != '0) begin
                launched = start_fe;
                pending  = launched;
                for (int i = 0; i < NPE; i++) due[i] = cyc + int'($urandom_range(5, 1));
                while (pending != '0 && !reset_N) begin
                    @(posedge clk); #1;
                    d = '0;
                    for (int i = 0; i < NPE; i++) if (pending[i] && due[i] <= cyc) d[i] = 1'b1;
                    if ($urandom_range(3) == 0) d = d | (~launched & NPE'($urandom()));
                    done_fe = d;
                    pending = pending & ~d;
                    if (pending == '0) last_final_cyc = cyc;
                end
                @(posedge clk); #1;
                done_fe = '0;
            end
        end
    endtask

    // Pops expectations whenever the DUT launches a batch or reports frame completion.
    task automatic monitor();
        int             launches;
        int             last_acc;
        bit             in_wait;
        logic [NPE-1:0] outstanding;
        launch_t        e;
        frame_t         f;
        int             exp_cyc;
        launches = 0; last_acc = -10; in_wait = 1'b0; outstanding = '0;
        forever begin
            @(negedge clk);
            if (reset_N) begin
                launches = 0; last_acc = -10; in_wait = 1'b0; outstanding = '0;
                continue;
            end
            if (dma_valid && dma_ready) last_acc = cyc;
            if (in_wait) begin
                chk("ready_during_wait", 64'(dma_ready), 64'(0));
                outstanding = outstanding & ~done_fe;
                if (outstanding == '0) in_wait = 1'b0;
            end
            if (start_fe != '0) begin
                chk("ready_at_launch", 64'(dma_ready), 64'(0));
                chk("launch_after_last_accept", 64'(cyc), 64'(last_acc + 1));
                chk("busy_at_launch", 64'(busy), 64'(1));
                if (exp_launch_q.size() == 0) begin
                    chk("unexpected_launch", 64'(start_fe), 64'(0));
                end else begin
                    e = exp_launch_q.pop_front();
                    chk("start_fe_mask", 64'(start_fe), 64'(e.mask));
                    chk("batch_idx", 64'(batch_idx), 64'(e.bidx));
                    for (int s = 0; s < NPE; s++) chk($sformatf("bbox_slot%0d", s), bbox_to_pe[s], e.data[s]);
                end
                launches++;
                in_wait     = 1'b1;
                outstanding = start_fe;
            end
            if (done_dispatch) begin
                chk("busy_at_done", 64'(busy), 64'(1));
                if (exp_done_q.size() == 0) begin
                    chk("unexpected_done_dispatch", 64'(done_dispatch), 64'(0));
                end else begin
                    f = exp_done_q.pop_front();
                    chk("batches_per_frame", 64'(launches), 64'(f.nbatch));
                    exp_cyc = f.empty ? (f.start_cyc + 1) : (last_final_cyc + 1);
                    chk("done_dispatch_cycle", 64'(cyc), 64'(exp_cyc));
                end
                launches = 0;
            end
        end
    endtask

    // Waits (bounded) for the scoreboard to drain, then idles two cycles.
    task automatic wait_frame();
        int guard;
        guard = 0;
        while ((exp_done_q.size() != 0 || exp_launch_q.size() != 0) && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 3000) begin
            chk("frame_timeout", 64'(exp_done_q.size() + exp_launch_q.size()), 64'(0));
            exp_done_q.delete();
            exp_launch_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_launch();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (start_fe != '0) return;
        end
        chk("launch_timeout", 64'(start_fe), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dma_ready"}, 64'(dma_ready), 64'(0));
        chk({tag, "_start_fe"}, 64'(start_fe), 64'(0));
        chk({tag, "_batch_idx"}, 64'(batch_idx), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done_dispatch"}, 64'(done_dispatch), 64'(0));
        for (int s = 0; s < NPE; s++) chk($sformatf("%s_bbox%0d", tag, s), bbox_to_pe[s], 64'(0));
    endtask

    initial begin
        reset_N     = 1'b1;
        start_frame = 1'b0;
        num_of_bbox = '0;
        dma_valid   = 1'b0;
        dma_bbox    = '0;
        done_fe     = '0;
        for (int s = 0; s < NPE; s++) model_slots[s] = '0;

        fork
            monitor();
            pe_responder();
        join_none

        repeat (3) @(posedge clk);
        #1;
        reset_N = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Single partial batch, PEs answer 2,0,1 on separate cycles.
        pe_auto = 1'b0;
        start_new_frame(3);
        dma_feed(3, 0, 1'b0, 16'h0);
        @(posedge clk); #1; done_fe = 8'h04;
        @(posedge clk); #1; done_fe = 8'h01;
        @(posedge clk); #1; done_fe = 8'h02; last_final_cyc = cyc;
        @(posedge clk); #1; done_fe = 8'h00;
        wait_frame();

        // Multi-batch 19 = 8+8+3 with back-to-back valid.
        pe_auto = 1'b1;
        start_new_frame(19);
        dma_feed(19, 0, 1'b0, 16'h0);
        wait_frame();

        // Empty frame.
        start_new_frame(0);
        @(negedge clk);
        chk("empty_done_cycle", 64'(done_dispatch), 64'(1));
        chk("empty_busy", 64'(busy), 64'(1));
        chk("empty_ready", 64'(dma_ready), 64'(0));
        @(negedge clk);
        chk("empty_done_after", 64'(done_dispatch), 64'(0));
        chk("empty_busy_after", 64'(busy), 64'(0));
        chk("empty_start_fe", 64'(start_fe), 64'(0));
        wait_frame();

        // Valid pattern 1,0,0,1 for two bboxes.
        start_new_frame(2);
        dma_feed(2, 0, 1'b1, 16'b1001);
        wait_frame();

        // Stray + simultaneous done, and a start_frame while busy.
        pe_auto = 1'b0;
        start_new_frame(3);
        dma_feed(3, 0, 1'b0, 16'h0);
        @(posedge clk); #1; done_fe = 8'h83; start_frame = 1'b1; num_of_bbox = CW'(5);
        @(posedge clk); #1; done_fe = 8'h00; start_frame = 1'b0;
        @(negedge clk);
        chk("no_early_done", 64'(done_dispatch), 64'(0));
        @(posedge clk); #1; done_fe = 8'h04; last_final_cyc = cyc;
        @(posedge clk); #1; done_fe = 8'h00;
        wait_frame();
        repeat (6) @(negedge clk);
        chk("ignored_start_busy", 64'(busy), 64'(0));
        chk("ignored_start_fe", 64'(start_fe), 64'(0));

        // Reset during WAIT of batch 1, with a done_fe in flight.
        dma_abort = 1'b0;
        start_new_frame(19);
        fork
            dma_feed(19, 0, 1'b0, 16'h0);
            begin
                wait_launch();
                @(posedge clk); #1; done_fe = 8'hFF;
                @(posedge clk); #1; done_fe = 8'h00;
                wait_launch();
                @(posedge clk); #1; done_fe = 8'h0F; reset_N = 1'b1; dma_abort = 1'b1;
                @(posedge clk); #1; done_fe = 8'h00; reset_N = 1'b0;
                exp_launch_q.delete();
                exp_done_q.delete();
                for (int s = 0; s < NPE; s++) model_slots[s] = '0;
                @(negedge clk);
                check_reset_outputs("midreset");
                repeat (3) @(negedge clk);
                chk("midreset_no_done", 64'(done_dispatch), 64'(0));
            end
        join
        dma_abort = 1'b0;
        @(posedge clk); #1;

        // Clean frame after reset, then random frames including the maximum count.
        pe_auto = 1'b1;
        start_new_frame(11);
        dma_feed(11, 20, 1'b0, 16'h0);
        wait_frame();
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(40, 1));
            start_new_frame(n);
            dma_feed(n, 30, 1'b0, 16'h0);
            wait_frame();
        end
        start_new_frame(int'(MAXB));
        dma_feed(int'(MAXB), 10, 1'b0, 16'h0);
        wait_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
